sprite_line_scheduler: RTL

SPRITE_LINE_SCHEDULER -- requirements
Module: sprite_line_scheduler

---
 rtl/sprite_line_scheduler.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/sprite_line_scheduler.sv
// Per-scanline sprite evaluator: scans the sprite table during horizontal blank, then composites the next line.
// Optional overflow tracking is built when SPRITE_OVERFLOW_EN is defined.
module sprite_line_scheduler #(
  parameter int NUM_SPR   = 8,
  parameter int NUM_SLOTS = 4,
  parameter int SPR_SIZE  = 16
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic [9:0]                  DrawX,
  input  logic [9:0]                  DrawY,
  input  logic                        blank,
  output logic [$clog2(NUM_SPR)-1:0]  spr_addr,
  input  logic [9:0]                  spr_x,
  input  logic [9:0]                  spr_y,
  input  logic                        spr_valid,
  output logic                        chef,
  output logic [$clog2(NUM_SPR)-1:0]  pix_id,
  output logic [$clog2(SPR_SIZE)-1:0] pix_row,
  output logic [$clog2(SPR_SIZE)-1:0] pix_col,
  output logic                        line_overflow
);
  localparam int AW = $clog2(NUM_SPR);
  localparam int SW = $clog2(SPR_SIZE);
  localparam int CW = $clog2(NUM_SLOTS + 1);

  typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;

  state_t               state_q, state_d;
  logic [AW-1:0]        idx_q, idx_d;
  logic [CW-1:0]        sh_cnt_q, sh_cnt_d;
  logic [NUM_SLOTS-1:0] sh_vld_q, sh_vld_d, act_vld_q, act_vld_d;
  logic [AW-1:0]        sh_id_q  [NUM_SLOTS], sh_id_d  [NUM_SLOTS];
  logic [9:0]           sh_x_q   [NUM_SLOTS], sh_x_d   [NUM_SLOTS];
  logic [SW-1:0]        sh_row_q [NUM_SLOTS], sh_row_d [NUM_SLOTS];
  logic [AW-1:0]        act_id_q [NUM_SLOTS], act_id_d [NUM_SLOTS];
  logic [9:0]           act_x_q  [NUM_SLOTS], act_x_d  [NUM_SLOTS];
  logic [SW-1:0]        act_row_q[NUM_SLOTS], act_row_d[NUM_SLOTS];

  logic                 chef_q, chef_d;
  logic [AW-1:0]        pix_id_q, pix_id_d;
  logic [SW-1:0]        pix_row_q, pix_row_d, pix_col_q, pix_col_d;

  logic [9:0]           next_line, hit_dy, col_dx;
  logic                 hit, line_end, cover_any;
  logic [AW-1:0]        win_id;
  logic [SW-1:0]        win_row, win_col;

  // Scan FSM, shadow slot fill and end-of-line shadow-to-active copy
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    sh_cnt_d  = sh_cnt_q;
    sh_vld_d  = sh_vld_q;
    sh_id_d   = sh_id_q;
    sh_x_d    = sh_x_q;
    sh_row_d  = sh_row_q;
    act_vld_d = act_vld_q;
    act_id_d  = act_id_q;
    act_x_d   = act_x_q;
    act_row_d = act_row_q;
    next_line = (DrawY == 10'd524) ? 10'd0 : DrawY + 10'd1;
    hit_dy    = next_line - spr_y;
    hit       = (state_q == SCAN) && spr_valid && (hit_dy < 10'(SPR_SIZE));
    line_end  = (DrawX == 10'd799);
    spr_addr  = (state_q == SCAN) ? idx_q : '0;

    case (state_q)
      IDLE: if (DrawX == 10'd640) begin
        state_d = SCAN;
        idx_d   = '0;
      end
      SCAN: begin
        idx_d = idx_q + AW'(1);
        if (idx_q == AW'(NUM_SPR - 1)) state_d = HOLD;
      end
      HOLD: if (line_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (hit && (sh_cnt_q < CW'(NUM_SLOTS))) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (CW'(i) == sh_cnt_q) begin
          sh_vld_d[i] = 1'b1;
          sh_id_d[i]  = idx_q;
          sh_x_d[i]   = spr_x;
          sh_row_d[i] = hit_dy[SW-1:0];
        end
      end
      sh_cnt_d = sh_cnt_q + CW'(1);
    end

    // An unfinished scan still hands over whatever it collected
    if (line_end) begin
      act_vld_d = sh_vld_q;
      act_id_d  = sh_id_q;
      act_x_d   = sh_x_q;
      act_row_d = sh_row_q;
      sh_vld_d  = '0;
      sh_cnt_d  = '0;
      state_d   = IDLE;
    end
  end

  // Pixel compositing: lowest-numbered covering slot wins
  always_comb begin
    cover_any = 1'b0;
    win_id    = '0;
    win_row   = '0;
    win_col   = '0;
    col_dx    = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      col_dx = DrawX - act_x_q[i];
      if (act_vld_q[i] && (col_dx < 10'(SPR_SIZE))) begin
        cover_any = 1'b1;
        win_id    = act_id_q[i];
        win_row   = act_row_q[i];
        win_col   = col_dx[SW-1:0];
      end
    end
    chef_d    = blank && cover_any;
    pix_id_d  = chef_d ? win_id  : '0;
    pix_row_d = chef_d ? win_row : '0;
    pix_col_d = chef_d ? win_col : '0;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      sh_cnt_q  <= '0;
      sh_vld_q  <= '0;
      act_vld_q <= '0;
      chef_q    <= 1'b0;
      pix_id_q  <= '0;
      pix_row_q <= '0;
      pix_col_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      sh_cnt_q  <= sh_cnt_d;
      sh_vld_q  <= sh_vld_d;
      act_vld_q <= act_vld_d;
      chef_q    <= chef_d;
      pix_id_q  <= pix_id_d;
      pix_row_q <= pix_row_d;
      pix_col_q <= pix_col_d;
    end
  end

  // Slot payloads are qualified by the valid bits, so they need no reset
  always_ff @(posedge Clk) begin
    sh_id_q   <= sh_id_d;
    sh_x_q    <= sh_x_d;
    sh_row_q  <= sh_row_d;
    act_id_q  <= act_id_d;
    act_x_q   <= act_x_d;
    act_row_q <= act_row_d;
  end

  assign chef    = chef_q;
  assign pix_id  = pix_id_q;
  assign pix_row = pix_row_q;
  assign pix_col = pix_col_q;

`ifdef SPRITE_OVERFLOW_EN
  logic sh_ovf_q, sh_ovf_d, act_ovf_q, act_ovf_d;

  always_comb begin
    sh_ovf_d  = sh_ovf_q;
    act_ovf_d = act_ovf_q;
    if (hit && (sh_cnt_q == CW'(NUM_SLOTS))) sh_ovf_d = 1'b1;
    if (line_end) begin
      act_ovf_d = sh_ovf_q;
      sh_ovf_d  = 1'b0;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sh_ovf_q  <= 1'b0;
      act_ovf_q <= 1'b0;
    end else begin
      sh_ovf_q  <= sh_ovf_d;
      act_ovf_q <= act_ovf_d;
    end
  end

  assign line_overflow = act_ovf_q;
`else
  assign line_overflow = 1'b0;
`endif

endmodule
